uart_rx_frame_fsm: RTL and testbench
====================================

// Module: uart_rx_frame_fsm
// PURPOSE
//  UART receive front end. Synchronises the serial line, detects a start bit and
//  samples each bit at mid-bit using an oversampling baud tick. Assembles the
//  8-bit byte LSB-first, captures the parity bit and checks the stop bit.
//  Drives data_received/parity_bit_rx/parity_load straight into Rx_parity_checker
//  (even parity, combinational) and flags framing errors itself.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick pulses per bit period; must be even and >= 4
//  DATA_BITS   8   data bits per frame; fixed at 8 to match the parity checker
//  PARITY_EN   1   1: frame carries a parity bit; 0: go DATA -> STOP directly
// PORTS
//  clk            in   1  system clock; everything is on the rising edge
//  rst_n          in   1  reset; synchronous and active-low
//  baud_tick      in   1  1-clk strobe, OVERSAMPLE strobes per bit period
//  rx_in          in   1  asynchronous serial line; idles high
//  data_received  out  8  last assembled byte; held until the next frame completes
//  parity_bit_rx  out  1  parity bit sampled from the last frame (0 if PARITY_EN=0)
//  parity_load    out  1  1-clk pulse: data_received/parity_bit_rx valid for checker
//  data_valid     out  1  1-clk pulse: frame complete and stop bit == 1
//  stop_error     out  1  1-clk pulse: frame complete and stop bit == 0 (framing)
//  rx_busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, both sync flops=1, tick_cnt=0,
//   bit_cnt=0, shift=0, data_received=0, parity_bit_rx=0, and parity_load,
//   data_valid, stop_error and rx_busy are all 0.
//   A reset mid-frame abandons the frame with no pulses.
//  rx_in passes through a 2-FF synchroniser (rx_s), plus one more flop for edge detect.
//   The start edge is rx_s falling (prev=1, cur=0).
//  tick_cnt counts only on cycles with baud_tick=1.
//   Sampling decisions happen only on a baud_tick cycle.
//  States:
//   IDLE  : falling edge -> START with tick_cnt=0.
//   START : when tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//           if rx_s==0 -> DATA with tick_cnt=0, bit_cnt=0;
//           else false start -> IDLE with no outputs.
//   DATA  : when tick_cnt==OVERSAMPLE-1, shift rx_s into bit7 (shift right,
//           LSB-first) and reset tick_cnt. On the DATA_BITS-th sample go to
//           PARITY if PARITY_EN, else STOP.
//   PARITY: when tick_cnt==OVERSAMPLE-1, latch rx_s into a parity holding
//           register -> STOP.
//   STOP  : when tick_cnt==OVERSAMPLE-1, sample rx_s, then on that same edge:
//           load data_received<=shift and parity_bit_rx<=parity holding register;
//           pulse parity_load, plus data_valid (rx_s=1) or stop_error (rx_s=0).
//           Go to IDLE.
//  Output update is atomic: the outputs change only on the STOP-sample edge.
//   The parity checker therefore sees stable inputs for the whole parity_load
//   cycle and after it.
//  Frame latency: outputs update (OVERSAMPLE/2 + (DATA_BITS+PARITY_EN+1)*OVERSAMPLE)
//   ticks after the detected falling edge.
//  Stop bit = 0 (break or line held low): stop_error is pulsed, then IDLE.
//   A new frame needs a fresh falling edge, so a stuck-low line does not retrigger.
//  Back-to-back frames: the next start edge may arrive the cycle after the
//   return to IDLE, and it is accepted.
//  rx_in glitches shorter than half a bit that return high are rejected by the
//   START check.
// STRUCTURE
//  Package uart_pkg: state encodings (ST_IDLE..ST_STOP, 3-bit localparams),
//   UART_OVERSAMPLE=16, UART_DATA_BITS=8.
//   Shared with the tx side and the baud generator.
//  One sub-module: uart_rx_sync, the 2-FF synchroniser plus falling-edge detect
//   (ports clk, rst_n, rx_in, rx_s, fall).
//  The FSM, counters and shift register live in this module.
// TESTING
//  The bench divides clk so there is 1 baud_tick per 4 clk. Test points are
//   instantiated with the Rx_parity_checker attached.
//  1) Frame 0xA5, parity 0, stop 1 -> data_received=0xA5, parity_bit_rx=0, one
//     parity_load and one data_valid in the same cycle, parity_error=0.
//  2) Frame 0x01, parity 0 (wrong), stop 1 -> data_valid pulse, parity_error=1.
//     Then frame 0x03, parity 0 back-to-back -> 0x03, parity_error=0.
//  3) Frame 0x3C with stop bit 0 -> stop_error pulse, no data_valid, data_received=0x3C.
//     rx held low 3 bit-times -> no new frame, rx_busy=0.
//  4) rx low for 5 ticks then high -> false start: rx_busy falls back to 0 by tick 8,
//     no pulses, outputs unchanged.
//  5) rst_n low for 1 clk in the middle of DATA of frame 0xFF -> all outputs 0,
//     IDLE. A following 0x5A frame then decodes correctly.
//  6) PARITY_EN=0, frame 0x81 with stop 1 -> data_valid with parity_bit_rx=0.
//     Latency is 8+9*16 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver/transmitter state encodings and the
// default oversampling and data-width constants. Also used by the tx side
// and the baud generator.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line plus one extra flop
// for falling-edge detection. All flops reset to 1 (line idle level) so a
// reset never fabricates a start edge.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   rx_in in  asynchronous serial line
//   rx_s  out synchronised line level
//   fall  out 1 while the synchronised line has just gone 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain and previous-level flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule : uart_rx_sync

// File: rtl/uart_rx_frame_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_fsm
// UART receive front end. Detects a start bit, samples every bit at mid-bit
// using the oversampling baud tick, assembles the byte LSB-first, captures
// the parity bit and checks the stop bit. All frame outputs update together
// on the stop-bit sampling edge so the downstream parity checker sees stable
// inputs during and after the parity_load pulse.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   baud_tick       1-clk strobe, OVERSAMPLE strobes per bit period
//   rx_in           asynchronous serial line (idles high)
//   data_received   last assembled byte, held until the next frame completes
//   parity_bit_rx   parity bit of the last frame (0 when PARITY_EN=0)
//   parity_load     1-clk pulse: data_received/parity_bit_rx valid for checker
//   data_valid      1-clk pulse: frame complete with stop bit 1
//   stop_error      1-clk pulse: frame complete with stop bit 0
//   rx_busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int PARITY_EN  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx_in,
    output logic [7:0] data_received,
    output logic       parity_bit_rx,
    output logic       parity_load,
    output logic       data_valid,
    output logic       stop_error,
    output logic       rx_busy
);

    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [TC_W-1:0] TICK_HALF = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] TICK_LAST = TC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    uart_state_e     r_state,    w_state_nxt;
    logic [TC_W-1:0] r_tick_cnt, w_tick_nxt;
    logic [BC_W-1:0] r_bit_cnt,  w_bit_nxt;
    logic [7:0]      r_shift,    w_shift_nxt;
    logic            r_par_hold, w_par_hold_nxt;
    logic [7:0]      r_data,     w_data_nxt;
    logic            r_par,      w_par_nxt;
    logic            r_load,     w_load_nxt;
    logic            r_valid,    w_valid_nxt;
    logic            r_serr,     w_serr_nxt;
    logic            r_busy;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= 8'h00;
            r_par_hold <= 1'b0;
            r_data     <= 8'h00;
            r_par      <= 1'b0;
            r_load     <= 1'b0;
            r_valid    <= 1'b0;
            r_serr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_hold <= w_par_hold_nxt;
            r_data     <= w_data_nxt;
            r_par      <= w_par_nxt;
            r_load     <= w_load_nxt;
            r_valid    <= w_valid_nxt;
            r_serr     <= w_serr_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic; every sampling decision is gated by baud_tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_hold_nxt = r_par_hold;
        w_data_nxt     = r_data;
        w_par_nxt      = r_par;
        w_load_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_serr_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_tick_nxt  = '0;
                end else begin
                    w_tick_nxt  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_nxt = '0;
                        w_bit_nxt  = '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        if (!w_rx_s) begin
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick_cnt;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_nxt  = '0;
                        // LSB arrives first, so shift in from the top.
                        w_shift_nxt = {w_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            w_bit_nxt   = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick_cnt;
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_nxt     = '0;
                        w_par_hold_nxt = w_rx_s;
                        w_state_nxt    = ST_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick_cnt;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        // Frame outputs all change on this one edge.
                        w_tick_nxt  = '0;
                        w_data_nxt  = w_shift_nxt;
                        w_par_nxt   = (PARITY_EN != 0) ? r_par_hold : 1'b0;
                        w_load_nxt  = 1'b1;
                        w_valid_nxt = w_rx_s;
                        w_serr_nxt  = ~w_rx_s;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
    end

    assign data_received = r_data;
    assign parity_bit_rx = r_par;
    assign parity_load   = r_load;
    assign data_valid    = r_valid;
    assign stop_error    = r_serr;
    assign rx_busy       = r_busy;

endmodule : uart_rx_frame_fsm

// File: tb/tb_uart_rx_frame_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_fsm
// Directed frames into two receivers (parity enabled / disabled). Expected
// frame results are queued when a frame is launched; monitors pop and compare
// whenever a receiver pulses parity_load, data_valid or stop_error.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_fsm;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, 4 clk per tick

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx1;
    logic       rx2;
    logic [1:0] div = 2'd0;
    logic       baud_tick;

    always @(posedge clk) div <= div + 2'd1;
    assign baud_tick = (div == 2'd3);

    int unsigned tick_total = 0;
    always @(posedge clk) if (baud_tick) tick_total <= tick_total + 1;

    logic [7:0] d1, d2;
    logic       p1, pl1, dv1, se1, bz1;
    logic       p2, pl2, dv2, se2, bz2;
    logic       perr1;

    // Even-parity checker attached to the parity-enabled receiver.
    assign perr1 = ^{d1, p1};

    uart_rx_frame_fsm #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx1),
        .data_received(d1), .parity_bit_rx(p1), .parity_load(pl1),
        .data_valid(dv1), .stop_error(se1), .rx_busy(bz1)
    );

    uart_rx_frame_fsm #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx2),
        .data_received(d2), .parity_bit_rx(p2), .parity_load(pl2),
        .data_valid(dv2), .stop_error(se2), .rx_busy(bz2)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       valid;
        logic       serr;
        logic       perr;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned start_tick  = 0;
    int unsigned pulse_tick1 = 0;
    int unsigned pulse_tick2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor for the parity-enabled receiver.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (pl1 === 1'b1 || dv1 === 1'b1 || se1 === 1'b1) begin
            pulse_tick1 = tick_total;
            if (q1.size() == 0) begin
                chk("unexpected_out1", {pl1, dv1, se1}, 3'b000);
            end else begin
                e = q1.pop_front();
                chk("data1",        d1,    e.data);
                chk("par1",         p1,    e.par);
                chk("load1",        pl1,   1'b1);
                chk("valid1",       dv1,   e.valid);
                chk("stop_err1",    se1,   e.serr);
                chk("parity_err1",  perr1, e.perr);
            end
        end
    end

    // Scoreboard monitor for the parity-disabled receiver.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (pl2 === 1'b1 || dv2 === 1'b1 || se2 === 1'b1) begin
            pulse_tick2 = tick_total;
            if (q2.size() == 0) begin
                chk("unexpected_out2", {pl2, dv2, se2}, 3'b000);
            end else begin
                e = q2.pop_front();
                chk("data2",     d2,  e.data);
                chk("par2",      p2,  e.par);
                chk("load2",     pl2, 1'b1);
                chk("valid2",    dv2, e.valid);
                chk("stop_err2", se2, e.serr);
            end
        end
    end

    task automatic drive(input bit which, input logic v);
        if (which) rx2 = v;
        else       rx1 = v;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Launch one frame and queue its expected result; leaves the line at the stop level.
    task automatic send_frame(input bit which, input logic [7:0] d, input logic p,
                              input logic s, input bit use_par, input logic perr);
        exp_t e;
        e.data  = d;
        e.par   = use_par ? p : 1'b0;
        e.valid = s;
        e.serr  = ~s;
        e.perr  = perr;
        if (which) q2.push_back(e);
        else       q1.push_back(e);
        drive(which, 1'b0);
        start_tick = tick_total;
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            hold_bits(1);
        end
        if (use_par) begin
            drive(which, p);
            hold_bits(1);
        end
        drive(which, s);
        hold_bits(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lat;
        rst_n = 1'b0;
        rx1   = 1'b1;
        rx2   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  d1,  8'h00);
        chk("rst_par",   p1,  1'b0);
        chk("rst_load",  pl1, 1'b0);
        chk("rst_valid", dv1, 1'b0);
        chk("rst_serr",  se1, 1'b0);
        chk("rst_busy",  bz1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold_bits(1);

        // 1) 0xA5, parity 0, stop 1; latency 8 + 10*16 ticks
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        hold_bits(1);
        lat = pulse_tick1 - start_tick;
        chk("latency1", (lat == 32'd168 || lat == 32'd169), 1'b1);

        // 2) wrong parity then a back-to-back good frame
        send_frame(1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        hold_bits(1);

        // 3) stop bit 0, then the line stuck low for 3 bit-times
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        hold_bits(3);
        chk("stuck_low_busy", bz1, 1'b0);
        drive(1'b0, 1'b1);
        hold_bits(1);

        // 4) 5-tick glitch is rejected at mid start bit
        drive(1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1 chk("glitch_busy_hi", bz1, 1'b1);
        repeat (8) @(posedge clk);
        #1 drive(1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1 chk("glitch_busy_lo", bz1, 1'b0);
        chk("glitch_data", d1, 8'h3C);
        chk("glitch_par",  p1, 1'b0);
        hold_bits(1);

        // 5) reset in the middle of DATA of 0xFF, then 0x5A
        drive(1'b0, 1'b0);
        hold_bits(1);
        drive(1'b0, 1'b1);
        hold_bits(2);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_data",  d1,  8'h00);
        chk("mid_rst_par",   p1,  1'b0);
        chk("mid_rst_load",  pl1, 1'b0);
        chk("mid_rst_valid", dv1, 1'b0);
        chk("mid_rst_serr",  se1, 1'b0);
        chk("mid_rst_busy",  bz1, 1'b0);
        hold_bits(8);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        hold_bits(1);

        // 6) parity disabled: 0x81, latency 8 + 9*16 ticks
        send_frame(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        hold_bits(1);
        lat = pulse_tick2 - start_tick;
        chk("latency2", (lat == 32'd152 || lat == 32'd153), 1'b1);

        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_frame_fsm
